dclk_tx_lanes: RTL and testbench
================================

Name: dclk_tx_lanes

Overview:
- Parametrised successor to the single-wire dclk_tx link transmitter.
- Buffers flits from the local router port in a small FIFO and serialises each one over LANES parallel wires to the neighbouring router's receiver.
- Each frame carries a start beat and an even-parity beat.
- Honours channel_busy backpressure from the receiver.
- One instance per outgoing router direction.

Parameters:
- ID, 0, router identifier; used only in simulation $display messages.
- DIR, "east", output direction label; used only in simulation $display messages.
- DATA_W, `HDR_SZ+`PL_SZ+`ADDR_SZ, flit width in bits.
- LANES, 1, number of serial wires (1..DATA_W).
- DEPTH, 4, FIFO depth in flits; must be a power of two, at least 2.

Ports:
- clk  in  1  link clock
- reset  in  1  asynchronous, active-high reset
- req  in  1  one-cycle push strobe for parallel_in
- parallel_in  in  DATA_W  flit to transmit
- channel_busy  in  1  receiver cannot accept a new frame
- tx_busy  out  1  FIFO full; req is ignored while high
- serial_out  out  LANES  serial lanes; idle value is all zeros
- tx_active  out  1  a frame is on the wire (start, data or parity beat)
- overflow  out  1  sticky: a req arrived while tx_busy was high
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: serial_out=0, tx_active=0, tx_busy=0, overflow=0, level=0. FIFO pointers cleared; FSM returns to IDLE.
- Reset mid-frame: the wire drops to idle immediately and the partially sent frame is abandoned. The receiver is reset by the same signal.
- Derived constant: BEATS = ceil(DATA_W/LANES).
- Beat mapping: in data beat k, lane i carries flit bit k*LANES+i. Bit indices at or above DATA_W are sent as 0 (padding).
- Frame format: START (all lanes 1), then BEATS data beats, then PARITY. The PARITY beat carries lane0 = XOR of all DATA_W bits; all other lanes are 0.
- Frame length: BEATS+2 cycles.
- FIFO push: when req=1 and tx_busy=0 at an edge, parallel_in is written.
  - A req while full is dropped and sets overflow.
  - Push and pop in the same cycle are both honoured when not full.
  - When full, a same-cycle pop does not rescue a push (tx_busy is registered full).
- tx_busy = (level==DEPTH), registered.
- FSM states:
  - IDLE: if FIFO non-empty and channel_busy=0 at the edge, pop the head into the shift register, drive START, go to DATA with beat counter = 0. Otherwise hold the wire at 0.
  - DATA: drive beat counter's lanes; on counter == BEATS-1 go to PARITY; else increment.
  - PARITY: drive parity beat; go to GAP.
  - GAP: wire 0 for exactly one cycle so the receiver can raise channel_busy; go to IDLE.
- Backpressure: channel_busy is only sampled in IDLE. Once START is driven, the frame always completes, whatever channel_busy does.
- Latency: req sampled at edge E into an empty FIFO with channel idle gives:
  - START visible from E+1
  - data beat k visible from E+2+k
  - PARITY visible from E+2+BEATS
  - next START no earlier than E+4+BEATS
- Back-to-back frames have a minimum spacing of BEATS+3 cycles.
- tx_active is high during START, DATA and PARITY; low during IDLE and GAP.
- All outputs are registered.
- level wraps correctly through pointer wrap-around: pointers are $clog2(DEPTH)+1 bits, and full/empty are decided by the MSB comparison.

Decomposition:
- HDR_SZ, PL_SZ and ADDR_SZ continue to come from constants.v.
- Add to constants.v: LINK_START and LINK_IDLE lane values, and the FSM state encodings (TX_IDLE, TX_DATA, TX_PARITY, TX_GAP) so the matching dclk_rx_lanes can share them.
- One sub-module: link_fifo (parametrised DATA_W/DEPTH synchronous FIFO with level). It is reused by the receiver.

Test Plan:
- DATA_W=8, LANES=2; push 0x01 with channel idle -> serial_out sequence 11, 01, 00, 00, 00, 01 (parity), then 00. tx_active is high for exactly 6 cycles.
- Same configuration; push 0xFF -> 11, 11, 11, 11, 11, 00 (parity 0). Also set DATA_W=7, LANES=2 and push 0x7F -> last data beat is 01 (padding on lane1).
- channel_busy=1 held, push 4 flits with DEPTH=4 -> tx_busy=1, level=4, wire stays 00. A 5th req sets overflow=1 and level stays 4. Release channel_busy -> 4 frames leave in push order, each separated by one GAP cycle.
- Raise channel_busy during DATA beat 1 of a frame -> that frame completes unchanged; the next frame waits until channel_busy=0 is sampled in IDLE.
- Assert reset during DATA beat 2 -> serial_out=00 and tx_active=0 in the same cycle, and level=0. After release with no req the wire stays idle.
- LANES=1, default DATA_W; random pushes checked against a scoreboard that deserialises serial_out and checks parity -> zero mismatches over 1000 flits.

Source files
------------

// File: rtl/dclk_tx_lanes_pkg.sv
// Shared link constants for the lane-parallel transmitter and its matching receiver.
package dclk_tx_lanes_pkg;

    // Flit field sizes; the default flit is their sum.
    localparam int unsigned HDR_SZ  = 2;
    localparam int unsigned PL_SZ   = 8;
    localparam int unsigned ADDR_SZ = 6;

    // Per-lane wire values.
    localparam logic LINK_IDLE  = 1'b0;
    localparam logic LINK_START = 1'b1;

    // Transmitter FSM encodings, shared with the receiver.
    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_DATA   = 2'd1,
        TX_PARITY = 2'd2,
        TX_GAP    = 2'd3
    } tx_state_e;

    // Number of data beats needed to carry data_w bits over the given lane count.
    function automatic int unsigned beats_for(int unsigned data_w, int unsigned lanes);
        return (data_w + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/dclk_tx_lanes_link_fifo.sv
// Synchronous FIFO with registered full flag and occupancy, shared by link TX and RX.
module dclk_tx_lanes_link_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [DATA_W-1:0]       din,
    input  logic                    pop,
    output logic [DATA_W-1:0]       dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q;
    logic              full_q;
    logic              do_push;
    logic              do_pop;

    // A push while full is dropped even if a pop happens in the same cycle.
    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = full_q;
    assign level   = level_q;
    assign dout    = mem[rd_ptr_q[AW-1:0]];

    // Next pointer values; the extra MSB distinguishes full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer, occupancy and full-flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= wr_ptr_d - rd_ptr_d;
            full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                        (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/dclk_tx_lanes.sv
// Lane-parallel link transmitter: buffers flits and sends START, data beats, PARITY, GAP.
module dclk_tx_lanes
    import dclk_tx_lanes_pkg::*;
#(
    parameter int unsigned    ID     = 0,
    parameter logic [63:0]    DIR    = "east",
    parameter int unsigned    DATA_W = HDR_SZ + PL_SZ + ADDR_SZ,
    parameter int unsigned    LANES  = 1,
    parameter int unsigned    DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic [DATA_W-1:0]       parallel_in,
    input  logic                    channel_busy,
    output logic                    tx_busy,
    output logic [LANES-1:0]        serial_out,
    output logic                    tx_active,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned BEATS  = beats_for(DATA_W, LANES);
    localparam int unsigned SH_W   = BEATS * LANES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    tx_state_e         state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [SH_W-1:0]   shreg_q, shreg_d;
    logic              parity_q, parity_d;
    logic [LANES-1:0]  serial_q, serial_d;
    logic              active_q, active_d;
    logic              overflow_q, overflow_d;

    logic              pop;
    logic [DATA_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;

    // Identification parameters only label simulation messages.
    logic unused_params;
    assign unused_params = ^{ID, DIR};

    dclk_tx_lanes_link_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (req),
        .din    (parallel_in),
        .pop    (pop),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    assign tx_busy    = fifo_full;
    assign serial_out = serial_q;
    assign tx_active  = active_q;
    assign overflow   = overflow_q;

    // Next state and next wire value; each state sets the beat shown after the coming edge.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        serial_d   = {LANES{LINK_IDLE}};
        active_d   = 1'b0;
        pop        = 1'b0;
        overflow_d = overflow_q | (req & fifo_full);
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty && !channel_busy) begin
                    pop      = 1'b1;
                    shreg_d  = SH_W'(head);
                    parity_d = ^head;
                    serial_d = {LANES{LINK_START}};
                    active_d = 1'b1;
                    beat_d   = '0;
                    state_d  = TX_DATA;
                end
            end
            TX_DATA: begin
                // Low lanes of the shift register always hold the current beat.
                serial_d = shreg_q[LANES-1:0];
                shreg_d  = shreg_q >> LANES;
                active_d = 1'b1;
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = TX_PARITY;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            TX_PARITY: begin
                serial_d = LANES'(parity_q);
                active_d = 1'b1;
                state_d  = TX_GAP;
            end
            TX_GAP: begin
                // One idle cycle lets the receiver raise channel_busy before the next START.
                state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // FSM, datapath and registered-output state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            beat_q     <= '0;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            serial_q   <= '0;
            active_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_dclk_tx_lanes.sv
// Self-checking bench: three transmitter configurations against a beat-queue model.
module tb_dclk_tx_lanes;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance 0: DATA_W=8 LANES=2; instance 1: DATA_W=7 LANES=2; instance 2: defaults.
    logic        req0 = 0, req1 = 0, req2 = 0;
    logic        cb0 = 0, cb1 = 0, cb2 = 0;
    logic [7:0]  din0 = 0;
    logic [6:0]  din1 = 0;
    logic [15:0] din2 = 0;
    logic        busy0, busy1, busy2;
    logic [1:0]  so0, so1;
    logic [0:0]  so2;
    logic        act0, act1, act2;
    logic        ovf0, ovf1, ovf2;
    logic [2:0]  lvl0, lvl1, lvl2;

    dclk_tx_lanes #(.ID(0), .DATA_W(8), .LANES(2), .DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .parallel_in(din0), .channel_busy(cb0),
        .tx_busy(busy0), .serial_out(so0), .tx_active(act0), .overflow(ovf0), .level(lvl0)
    );
    dclk_tx_lanes #(.ID(1), .DATA_W(7), .LANES(2), .DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .parallel_in(din1), .channel_busy(cb1),
        .tx_busy(busy1), .serial_out(so1), .tx_active(act1), .overflow(ovf1), .level(lvl1)
    );
    dclk_tx_lanes #(.ID(2)) u_dut2 (
        .clk(clk), .reset(reset), .req(req2), .parallel_in(din2), .channel_busy(cb2),
        .tx_busy(busy2), .serial_out(so2), .tx_active(act2), .overflow(ovf2), .level(lvl2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Model state: flit queue per instance and the queue of wire beats still to appear.
    logic [15:0] fq [3][$];
    logic [2:0]  wq [3][$];   // {active, lane1, lane0}
    logic [2:0]  cur [3];
    logic        movf [3];
    logic [15:0] sb [$];
    int          sb_pushed = 0;
    int          sb_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dw_of(input int i);
        case (i)
            0: return 8;
            1: return 7;
            default: return 16;
        endcase
    endfunction

    function automatic int ln_of(input int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic logic [1:0] ser_of(input int i);
        case (i)
            0: return so0;
            1: return so1;
            default: return {1'b0, so2};
        endcase
    endfunction

    function automatic logic act_of(input int i);
        case (i)
            0: return act0;
            1: return act1;
            default: return act2;
        endcase
    endfunction

    function automatic logic busy_of(input int i);
        case (i)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic ovf_of(input int i);
        case (i)
            0: return ovf0;
            1: return ovf1;
            default: return ovf2;
        endcase
    endfunction

    function automatic logic [2:0] lvl_of(input int i);
        case (i)
            0: return lvl0;
            1: return lvl1;
            default: return lvl2;
        endcase
    endfunction

    // One clock edge of the model: a free link starts a whole frame, then the push is applied.
    task automatic model_step(input int i, input logic rq, input logic [15:0] din, input logic cb);
        int          dw;
        int          ln;
        int          nb;
        logic [15:0] f;
        logic [1:0]  v;
        bit          was_full;
        dw = dw_of(i);
        ln = ln_of(i);
        nb = (dw + ln - 1) / ln;
        was_full = (fq[i].size() == DEPTH);
        if (wq[i].size() == 0 && fq[i].size() != 0 && !cb) begin
            f = fq[i].pop_front();
            wq[i].push_back({1'b1, 2'((1 << ln) - 1)});
            for (int k = 0; k < nb; k++) begin
                v = '0;
                for (int j = 0; j < ln; j++) begin
                    if (k * ln + j < dw) v[j] = f[k * ln + j];
                end
                wq[i].push_back({1'b1, v});
            end
            wq[i].push_back({1'b1, 1'b0, ^f});
            wq[i].push_back(3'b000);
        end
        if (rq) begin
            if (was_full) begin
                movf[i] = 1'b1;
            end else begin
                f = din & 16'((1 << dw) - 1);
                fq[i].push_back(f);
                if (i == 2) begin
                    sb.push_back(f);
                    sb_pushed++;
                end
            end
        end
        cur[i] = (wq[i].size() != 0) ? wq[i].pop_front() : 3'b000;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            fq[i].delete();
            wq[i].delete();
            cur[i]  = 3'b000;
            movf[i] = 1'b0;
        end
        sb.delete();
        sb_pushed = 0;
    endtask

    // Model advances on every clock edge and clears on reset.
    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_clear();
            end else begin
                cyc++;
                model_step(0, req0, 16'(din0), cb0);
                model_step(1, req1, 16'(din1), cb1);
                model_step(2, req2, din2, cb2);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("i%0d.serial", i), 32'(ser_of(i)), 32'(cur[i][1:0]));
                check($sformatf("i%0d.tx_active", i), 32'(act_of(i)), 32'(cur[i][2]));
                check($sformatf("i%0d.tx_busy", i), 32'(busy_of(i)),
                      32'(fq[i].size() == DEPTH));
                check($sformatf("i%0d.overflow", i), 32'(ovf_of(i)), 32'(movf[i]));
                check($sformatf("i%0d.level", i), 32'(lvl_of(i)), 32'(fq[i].size()));
            end
        end
    end

    // Deserialising scoreboard for the single-lane instance.
    initial begin
        int          pos;
        logic [15:0] w;
        logic [15:0] e;
        pos = 0;
        w = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pos = 0;
            end else if (act2) begin
                if (pos == 0) begin
                    check("sb.start", 32'(so2), 32'd1);
                end else if (pos <= 16) begin
                    w[pos-1] = so2[0];
                end else if (pos == 17) begin
                    check("sb.parity", 32'(so2), 32'(^w));
                    if (sb.size() == 0) begin
                        check("sb.expected_flit", 32'd0, 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check("sb.flit", 32'(w), 32'(e));
                    end
                    sb_frames++;
                end
                pos++;
            end else begin
                if (pos != 0) check("sb.frame_len", 32'(pos), 32'd18);
                pos = 0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Waits for tx_active on instance i; an expired bound counts as a failure.
    task automatic wait_start(input int i, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (act_of(i)) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        check($sformatf("i%0d.start_timeout", i), 32'd0, 32'd1);
    endtask

    // Checks seven consecutive beats (frame plus gap) against literal wire and active values.
    task automatic expect_frame(input int i, input string tag, input logic [13:0] es,
                                input logic [6:0] ea);
        bit ok;
        wait_start(i, ok);
        if (ok) begin
            for (int b = 0; b < 7; b++) begin
                check($sformatf("%s.beat%0d", tag, b), 32'(ser_of(i)), 32'(es[2*(6-b) +: 2]));
                check($sformatf("%s.act%0d", tag, b), 32'(act_of(i)), 32'(ea[6-b]));
                tick();
            end
        end
    endtask

    initial begin
        bit          ok;
        int          last_start;
        logic [7:0]  w8;
        logic [31:0] order;
        int          c;

        // Reset values.
        tick(2);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("i%0d.rst_serial", i), 32'(ser_of(i)), 32'd0);
            check($sformatf("i%0d.rst_active", i), 32'(act_of(i)), 32'd0);
            check($sformatf("i%0d.rst_busy", i), 32'(busy_of(i)), 32'd0);
            check($sformatf("i%0d.rst_ovf", i), 32'(ovf_of(i)), 32'd0);
            check($sformatf("i%0d.rst_level", i), 32'(lvl_of(i)), 32'd0);
        end
        reset = 1'b0;
        tick(2);

        // 0x01 over two lanes.
        din0 = 8'h01; req0 = 1'b1; tick(); req0 = 1'b0;
        expect_frame(0, "f01", 14'b11_01_00_00_00_01_00, 7'b1111110);
        tick(2);

        // 0xFF: parity of eight ones is 0.
        din0 = 8'hFF; req0 = 1'b1; tick(); req0 = 1'b0;
        expect_frame(0, "fff", 14'b11_11_11_11_11_00_00, 7'b1111110);
        tick(2);

        // 7-bit flit: lane1 of the last data beat is padding.
        din1 = 7'h7F; req1 = 1'b1; tick(); req1 = 1'b0;
        expect_frame(1, "f7f", 14'b11_11_11_11_01_01_00, 7'b1111110);
        tick(2);

        // Fill the FIFO under backpressure, then overflow it.
        cb0 = 1'b1;
        order = 32'hA1B2C3D4;
        for (int f = 0; f < 4; f++) begin
            din0 = 8'(order >> (8 * (3 - f)));
            req0 = 1'b1;
            tick();
        end
        req0 = 1'b0;
        check("full.tx_busy", 32'(busy0), 32'd1);
        check("full.ovf_before", 32'(ovf0), 32'd0);
        din0 = 8'hEE; req0 = 1'b1; tick(); req0 = 1'b0; tick();
        check("full.ovf_after", 32'(ovf0), 32'd1);
        check("full.level", 32'(lvl0), 32'd4);
        check("full.wire", 32'(so0), 32'd0);
        cb0 = 1'b0;
        last_start = 0;
        for (int f = 0; f < 4; f++) begin
            wait_start(0, ok);
            if (ok) begin
                if (f > 0) check($sformatf("drain.spacing%0d", f), 32'(cyc - last_start), 32'd7);
                last_start = cyc;
                w8 = '0;
                for (int k = 0; k < 4; k++) begin
                    tick();
                    w8[2*k +: 2] = so0;
                end
                check($sformatf("drain.flit%0d", f), 32'(w8), 32'(8'(order >> (8 * (3 - f)))));
                tick(2);
            end
        end
        tick(2);

        // Backpressure raised mid-frame: frame completes, next one waits.
        din0 = 8'h5A; req0 = 1'b1; tick();
        din0 = 8'h3C; tick(); req0 = 1'b0;
        wait_start(0, ok);
        tick(2);
        cb0 = 1'b1;
        tick(12);
        check("bp.held_active", 32'(act0), 32'd0);
        check("bp.held_level", 32'(lvl0), 32'd1);
        cb0 = 1'b0;
        wait_start(0, ok);
        tick(8);

        // Reset during data beat 2.
        din0 = 8'h96; req0 = 1'b1; tick(); req0 = 1'b0;
        wait_start(0, ok);
        tick(3);
        #2 reset = 1'b1;
        #1;
        check("rst.serial", 32'(so0), 32'd0);
        check("rst.active", 32'(act0), 32'd0);
        check("rst.level", 32'(lvl0), 32'd0);
        tick();
        reset = 1'b0;
        tick(10);
        check("rst.idle_serial", 32'(so0), 32'd0);
        check("rst.idle_active", 32'(act0), 32'd0);

        // Random traffic on the single-lane instance.
        c = 0;
        while (c < 40000 && sb_pushed < 1000) begin
            req2 = ($urandom_range(0, 3) == 0);
            din2 = 16'($urandom);
            cb2  = ($urandom_range(0, 7) == 0);
            tick();
            c++;
        end
        req2 = 1'b0;
        cb2  = 1'b0;
        c = 0;
        while (c < 300 && (lvl2 != 0 || act2)) begin
            tick();
            c++;
        end
        tick(3);
        check("rand.pushed", 32'(sb_pushed >= 1000), 32'd1);
        check("rand.frames", 32'(sb_frames), 32'(sb_pushed));
        check("rand.sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
